// File: rtl/sign_phase_sequencer.sv
// Phase sequencer for the Picnic-on-SM4 signer: walks the sub-engine chain in order.
// Optional watchdog is built only when SIGN_SEQ_WDT_EN is defined.
module sign_phase_sequencer #(
    parameter int unsigned NUM_STAGES = 10,
    parameter int unsigned LOOP_STAGE = 3,
    parameter int unsigned NREP       = 8,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned WDT_CYCLES = 4096,
    localparam int unsigned SW        = $clog2(NUM_STAGES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [IDX_W-1:0]      rep_idx,
    output logic                  rep_capture,
    output logic [SW-1:0]         cur_stage,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [SW-1:0]    K_LOOP = SW'(LOOP_STAGE);
    localparam logic [SW-1:0]    K_LAST = SW'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] R_LAST = IDX_W'(NREP - 1);

    logic [2:0]    state;
    logic [SW-1:0] k;
    logic          cur_done;
    logic          wdt_trip;
    logic          kill;

    // stage_start is high only in RUN(k), so masking with it rejects stale dones
    assign cur_done = (state == S_RUN) && |(stage_done & stage_start);

    assign rep_capture = stage_start[LOOP_STAGE] & stage_done[LOOP_STAGE];

    assign cur_stage = (state == S_ARM || state == S_RUN || state == S_GAP)
                       ? k : SW'(NUM_STAGES);

    assign kill = (abort && state != S_IDLE) || wdt_trip;

`ifdef SIGN_SEQ_WDT_EN
    localparam int unsigned CW = $clog2(WDT_CYCLES + 1);

    logic [CW-1:0] wdt_cnt;

    // Per-stage cycle counter: zero outside RUN, so every ARM/GAP restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_cnt <= '0;
        end else if (state != S_RUN) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + CW'(1);
        end
    end

    assign wdt_trip = (state == S_RUN) && (wdt_cnt == CW'(WDT_CYCLES - 1));
`else
    // No watchdog: RUN waits forever; the parameter only keeps the interface uniform
    assign wdt_trip = 1'b0 & (WDT_CYCLES != 0);
`endif

    // Main sequencing FSM; abort/watchdog override any stage completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            k           <= '0;
            stage_start <= '0;
            rep_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else if (kill) begin
            state       <= S_IDLE;
            stage_start <= '0;
            rep_idx     <= '0;
            busy        <= 1'b0;
            error       <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                    end else if (!done && !error) begin
                        state <= S_ARM;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_ARM, S_GAP: begin
                    state       <= S_RUN;
                    stage_start <= NUM_STAGES'(1) << k;
                end
                S_RUN: begin
                    if (cur_done) begin
                        stage_start <= '0;
                        if (k == K_LOOP && rep_idx < R_LAST) begin
                            rep_idx <= rep_idx + IDX_W'(1);
                            state   <= S_GAP;
                        end else begin
                            if (k == K_LOOP) begin
                                rep_idx <= '0;
                            end
                            if (k == K_LAST) begin
                                state <= S_FIN;
                            end else begin
                                k     <= k + SW'(1);
                                state <= S_ARM;
                            end
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_phase_sequencer.sv
// Directed bench for sign_phase_sequencer with a 1-cycle responder.
// Watchdog expectations switch on SIGN_SEQ_WDT_EN.
module tb_sign_phase_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [9:0] stage_done;
    logic [9:0] stage_start;
    logic [7:0] rep_idx;
    logic       rep_capture;
    logic [4:0] cur_stage;
    logic       busy;
    logic       done;
    logic       error;

    logic [9:0] hold_mask;
    logic [9:0] extra;

    int n_checks;
    int n_errors;
    int stg_q[$];
    int cap_q[$];
    logic [9:0] prev;

    sign_phase_sequencer #(
        .NUM_STAGES(10),
        .LOOP_STAGE(3),
        .NREP(8),
        .IDX_W(8),
        .WDT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .stage_done(stage_done),
        .stage_start(stage_start),
        .rep_idx(rep_idx),
        .rep_capture(rep_capture),
        .cur_stage(cur_stage),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // responder: each engine finishes in the cycle its start is seen
    assign stage_done = (stage_start & ~hold_mask) | extra;

    // log RUN entries and capture strobes mid-cycle
    always @(negedge clk) begin
        if (stage_start != 10'd0 && stage_start != prev) begin
            for (int i = 0; i < 10; i++) begin
                if (stage_start[i]) stg_q.push_back(i);
            end
        end
        prev = stage_start;
        if (rep_capture) cap_q.push_back(int'(rep_idx));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bit(input int b, input int lim, input string tag);
        int n;
        n = 0;
        while (!stage_start[b] && n < lim) begin
            tick(1);
            n++;
        end
        if (!stage_start[b]) check(tag, 0, 1);
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int exp_q[$];
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        hold_mask = '0;
        extra     = '0;
        prev      = '0;
        tick(2);
        check("rst_start", int'(stage_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(error), 0);
        check("rst_idx", int'(rep_idx), 0);
        check("rst_cur", int'(cur_stage), 10);
        reset = 1'b1;
        tick(1);

        // 1: full run with responder
        stg_q.delete();
        cap_q.delete();
        start = 1'b1;
        tick(1);
        check("t1_busy", int'(busy), 1);
        wait_done(200, n);
        check("t1_lat", n, 35);
        check("t1_busy_end", int'(busy), 0);
        check("t1_cur_end", int'(cur_stage), 10);
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        for (int i = 0; i < 8; i++) exp_q.push_back(3);
        for (int i = 4; i < 10; i++) exp_q.push_back(i);
        check("t1_nstg", stg_q.size(), 17);
        for (int i = 0; i < 17 && i < stg_q.size(); i++)
            check("t1_order", stg_q[i], exp_q[i]);
        check("t1_ncap", cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check("t1_capidx", cap_q[i], i);
        tick(3);
        check("t1_hold", int'(done), 1);
        start = 1'b0;
        tick(1);
        check("t1_clr", int'(done), 0);

        // 2: stage_done[3] stuck high
        cap_q.delete();
        extra = 10'b00_0000_1000;
        start = 1'b1;
        tick(1);
        wait_done(200, n);
        check("t2_lat", n, 35);
        check("t2_ncap", cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check("t2_capidx", cap_q[i], i);
        check("t2_idx", int'(rep_idx), 0);
        start = 1'b0;
        extra = '0;
        tick(1);

        // 3: abort in RUN(3) at rep 5
        start = 1'b1;
        n = 0;
        while (!(stage_start[3] && rep_idx == 8'd5) && n < 100) begin
            tick(1);
            n++;
        end
        check("t3_reach", int'(stage_start[3] && rep_idx == 8'd5), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t3_start", int'(stage_start), 0);
        check("t3_err", int'(error), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_idx", int'(rep_idx), 0);
        check("t3_done", int'(done), 0);
        tick(3);
        check("t3_reject", int'(busy), 0);
        check("t3_errhold", int'(error), 1);
        start = 1'b0;
        tick(1);
        check("t3_errclr", int'(error), 0);

        // 4: async reset in RUN(6)
        hold_mask = 10'b00_0100_0000;
        start = 1'b1;
        wait_bit(6, 100, "t4_reach");
        #2;
        reset = 1'b0;
        #1;
        check("t4_start", int'(stage_start), 0);
        check("t4_busy", int'(busy), 0);
        check("t4_idx", int'(rep_idx), 0);
        check("t4_cur", int'(cur_stage), 10);
        cap_q.delete();
        hold_mask = '0;
        reset = 1'b1;
        wait_done(200, n);
        check("t4_done", int'(done), 1);
        check("t4_ncap", cap_q.size(), 8);
        start = 1'b0;
        tick(1);

        // 5: stage 7 never completes
        hold_mask = 10'b00_1000_0000;
        start = 1'b1;
        wait_bit(7, 100, "t5_reach");
`ifdef SIGN_SEQ_WDT_EN
        tick(15);
        check("t5_pre", int'(error), 0);
        tick(1);
        check("t5_wdt", int'(error), 1);
        check("t5_start", int'(stage_start), 0);
`else
        tick(10000);
        check("t5_run", int'(stage_start), 128);
        check("t5_cur", int'(cur_stage), 7);
        check("t5_noerr", int'(error), 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
`endif
        start = 1'b0;
        hold_mask = '0;
        tick(1);

        // 6: abort together with stage_done[9]
        hold_mask = 10'b10_0000_0000;
        start = 1'b1;
        wait_bit(9, 100, "t6_reach");
        extra = 10'b10_0000_0000;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        extra = '0;
        check("t6_err", int'(error), 1);
        check("t6_done", int'(done), 0);
        tick(3);
        check("t6_done2", int'(done), 0);
        start = 1'b0;
        hold_mask = '0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
